// File: rtl/drf_isa_pkg.sv
// ISA definitions shared by the drf control unit and its instruction decoder.
package drf_isa_pkg;

   // Instruction field layout
   localparam int unsigned INSTR_W     = 16;
   localparam int unsigned OPC_MSB     = 15;
   localparam int unsigned OPC_LSB     = 11;
   localparam int unsigned RX_MSB      = 10;
   localparam int unsigned RX_LSB      = 8;
   localparam int unsigned RY_MSB      = 7;
   localparam int unsigned RY_LSB      = 5;
   localparam int unsigned IMM_MSB     = 7;
   localparam int unsigned IMM_LSB     = 0;
   localparam int unsigned IMM_FIELD_W = 8;

   // Opcodes
   localparam logic [4:0] OPC_NOP  = 5'b00000;
   localparam logic [4:0] OPC_MOV  = 5'b00001;
   localparam logic [4:0] OPC_LDI  = 5'b00010;
   localparam logic [4:0] OPC_ADD  = 5'b00100;
   localparam logic [4:0] OPC_SUB  = 5'b00101;
   localparam logic [4:0] OPC_AND  = 5'b00110;
   localparam logic [4:0] OPC_OR   = 5'b00111;
   localparam logic [4:0] OPC_CMP  = 5'b01000;
   localparam logic [4:0] OPC_IN   = 5'b01001;
   localparam logic [4:0] OPC_OUT  = 5'b01010;
   localparam logic [4:0] OPC_JMP  = 5'b10000;
   localparam logic [4:0] OPC_JZ   = 5'b10001;
   localparam logic [4:0] OPC_JNZ  = 5'b10010;
   localparam logic [4:0] OPC_JC   = 5'b10011;
   localparam logic [4:0] OPC_HALT = 5'b11111;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_DECODE  = 2'd1,
      ST_EXECUTE = 2'd2,
      ST_HALT    = 2'd3
   } state_e;

   // Source of reg_in_data
   localparam logic [1:0] SEL_ALU  = 2'd0;
   localparam logic [1:0] SEL_IMM  = 2'd1;
   localparam logic [1:0] SEL_PORT = 2'd2;
   localparam logic [1:0] SEL_RY   = 2'd3;

   // ALU operations
   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_AND = 2'd2;
   localparam logic [1:0] ALU_OR  = 2'd3;

   // Jump conditions
   localparam logic [2:0] JMP_NONE   = 3'd0;
   localparam logic [2:0] JMP_ALWAYS = 3'd1;
   localparam logic [2:0] JMP_Z      = 3'd2;
   localparam logic [2:0] JMP_NZ     = 3'd3;
   localparam logic [2:0] JMP_C      = 3'd4;

endpackage

// File: rtl/drf_instr_decoder.sv
// Combinational decode of the instruction register into field values and intents.
// Intents are raw; the control unit qualifies them with the EXECUTE state.
module drf_instr_decoder
   import drf_isa_pkg::*;
(
   input  logic [15:0] ir,
   output logic [2:0]  rx_sel,
   output logic [2:0]  ry_sel,
   output logic [7:0]  imm,
   output logic [1:0]  reg_in_sel,
   output logic [1:0]  alu_op,
   output logic        reg_wr,
   output logic        flag_wr,
   output logic        port_wr,
   output logic [2:0]  jump_type,
   output logic        is_halt
);

   logic [4:0] opcode_s;

   assign opcode_s = ir[OPC_MSB:OPC_LSB];
   assign rx_sel   = ir[RX_MSB:RX_LSB];
   assign ry_sel   = ir[RY_MSB:RY_LSB];
   assign imm      = ir[IMM_MSB:IMM_LSB];

   // Opcode table: unlisted opcodes fall through to NOP behaviour
   always_comb begin
      reg_in_sel = SEL_ALU;
      alu_op     = ALU_ADD;
      reg_wr     = 1'b0;
      flag_wr    = 1'b0;
      port_wr    = 1'b0;
      jump_type  = JMP_NONE;
      is_halt    = 1'b0;
      case (opcode_s)
         OPC_MOV: begin
            reg_wr     = 1'b1;
            reg_in_sel = SEL_RY;
         end
         OPC_LDI: begin
            reg_wr     = 1'b1;
            reg_in_sel = SEL_IMM;
         end
         OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: begin
            reg_wr     = 1'b1;
            flag_wr    = 1'b1;
            reg_in_sel = SEL_ALU;
            alu_op     = opcode_s[1:0];
         end
         OPC_CMP: begin
            flag_wr = 1'b1;
            alu_op  = ALU_SUB;
         end
         OPC_IN: begin
            reg_wr     = 1'b1;
            reg_in_sel = SEL_PORT;
         end
         OPC_OUT:  port_wr   = 1'b1;
         OPC_JMP:  jump_type = JMP_ALWAYS;
         OPC_JZ:   jump_type = JMP_Z;
         OPC_JNZ:  jump_type = JMP_NZ;
         OPC_JC:   jump_type = JMP_C;
         OPC_HALT: is_halt   = 1'b1;
         default:  is_halt   = 1'b0;
      endcase
   end

endmodule

// File: rtl/drf_control_unit.sv
// Three-cycle FETCH/DECODE/EXECUTE sequencer driving the drf register bank.
module drf_control_unit
   import drf_isa_pkg::*;
#(
   parameter int PC_WIDTH  = 8,
   parameter int IMM_WIDTH = 8
)(
   input  logic                 clk,
   input  logic                 reset,
   output logic [PC_WIDTH-1:0]  pc_out,
   input  logic [15:0]          instruction,
   input  logic [1:0]           flags,
   output logic [2:0]           in_rx_selector,
   output logic [2:0]           in_ry_selector,
   output logic                 reg_write_en,
   output logic [1:0]           reg_in_sel,
   output logic [IMM_WIDTH-1:0] imm,
   output logic [1:0]           alu_op,
   output logic                 flags_write_en,
   output logic                 port_write_en,
   output logic                 halted
);

   state_e                          state_q, state_d;
   logic [PC_WIDTH-1:0]             pc_q, pc_d;
   logic [15:0]                     ir_q, ir_d;

   logic [IMM_FIELD_W-1:0]          dec_imm_s;
   logic                            dec_reg_wr_s, dec_flag_wr_s, dec_port_wr_s, dec_halt_s;
   logic [2:0]                      dec_jump_s;
   logic                            jump_taken_s, in_execute_s;
   logic [PC_WIDTH+IMM_FIELD_W-1:0] tgt_wide_s;
   logic [IMM_WIDTH+IMM_FIELD_W-1:0] imm_wide_s;
   logic [PC_WIDTH-1:0]             jump_target_s;

   drf_instr_decoder u_dec (
      .ir         (ir_q),
      .rx_sel     (in_rx_selector),
      .ry_sel     (in_ry_selector),
      .imm        (dec_imm_s),
      .reg_in_sel (reg_in_sel),
      .alu_op     (alu_op),
      .reg_wr     (dec_reg_wr_s),
      .flag_wr    (dec_flag_wr_s),
      .port_wr    (dec_port_wr_s),
      .jump_type  (dec_jump_s),
      .is_halt    (dec_halt_s)
   );

   // Zero-extend then truncate the 8-bit immediate to the PC and imm port widths
   assign tgt_wide_s    = {{PC_WIDTH{1'b0}}, dec_imm_s};
   assign jump_target_s = tgt_wide_s[PC_WIDTH-1:0];
   assign imm_wide_s    = {{IMM_WIDTH{1'b0}}, dec_imm_s};
   assign imm           = imm_wide_s[IMM_WIDTH-1:0];

   // Branch resolution against the live flags ({C, Z}) seen during EXECUTE
   always_comb begin
      case (dec_jump_s)
         JMP_ALWAYS: jump_taken_s = 1'b1;
         JMP_Z:      jump_taken_s = flags[0];
         JMP_NZ:     jump_taken_s = ~flags[0];
         JMP_C:      jump_taken_s = flags[1];
         default:    jump_taken_s = 1'b0;
      endcase
   end

   // Next-state, next-PC and IR capture for the three-phase sequence
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            ir_d    = instruction;
            state_d = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            if (jump_taken_s) begin
               pc_d = jump_target_s;
            end else begin
               pc_d = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
            end
            state_d = dec_halt_s ? ST_HALT : ST_FETCH;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_FETCH;
      endcase
   end

   // Sequencer registers; reset overrides any pending update
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FETCH;
         pc_q    <= {PC_WIDTH{1'b0}};
         ir_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Strobes are live only in EXECUTE and are killed by a coincident reset
   assign in_execute_s   = (state_q == ST_EXECUTE) && !reset;
   assign reg_write_en   = dec_reg_wr_s  && in_execute_s;
   assign flags_write_en = dec_flag_wr_s && in_execute_s;
   assign port_write_en  = dec_port_wr_s && in_execute_s;
   assign halted         = (state_q == ST_HALT);
   assign pc_out         = pc_q;

endmodule

// File: tb/tb_drf_control_unit.sv
// Randomized program bench for drf_control_unit with an instruction-level model.
module tb_drf_control_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  pc_out;
   logic [15:0] instruction;
   logic [1:0]  flags;
   logic [2:0]  in_rx_selector, in_ry_selector;
   logic        reg_write_en, flags_write_en, port_write_en, halted;
   logic [1:0]  reg_in_sel, alu_op;
   logic [7:0]  imm;

   logic [15:0] rom [256];
   logic [7:0]  model_pc;
   int          n_checks = 0;
   int          n_pass   = 0;

   drf_control_unit #(.PC_WIDTH(8), .IMM_WIDTH(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .pc_out         (pc_out),
      .instruction    (instruction),
      .flags          (flags),
      .in_rx_selector (in_rx_selector),
      .in_ry_selector (in_ry_selector),
      .reg_write_en   (reg_write_en),
      .reg_in_sel     (reg_in_sel),
      .imm            (imm),
      .alu_op         (alu_op),
      .flags_write_en (flags_write_en),
      .port_write_en  (port_write_en),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   // Synchronous program ROM: data valid one cycle after the address
   always @(posedge clk) instruction <= rom[pc_out];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [15:0] rand_word();
      logic [4:0]  opc_tab [15];
      logic [31:0] r;
      logic [4:0]  opc;
      opc_tab = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                  5'd9, 5'd10, 5'd16, 5'd17, 5'd18, 5'd19, 5'd0};
      r = $urandom;
      if ($urandom_range(0, 7) == 0) opc = 5'($urandom_range(0, 30));
      else opc = opc_tab[$urandom_range(0, 14)];
      return {opc, r[10:0]};
   endfunction

   // Hold reset two cycles, check the reset state, release on a falling edge
   task automatic reset_dut();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_pc", 32'(pc_out), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_strobes", {29'h0, reg_write_en, flags_write_en, port_write_en}, 32'h0);
      chk("rst_sel", {26'h0, in_rx_selector, in_ry_selector}, 32'h0);
      reset = 1'b0;
      model_pc = 8'h00;
      #1;
   endtask

   // One full instruction starting at its FETCH cycle; ends at the following cycle
   task automatic run_instr(input logic [1:0] f, output bit hit_halt);
      logic [15:0] w;
      logic [4:0]  opc;
      bit          e_wr, e_flg, e_port, taken;
      logic [1:0]  e_sel, e_alu;
      w   = rom[model_pc];
      opc = w[15:11];
      chk("fetch_pc", 32'(pc_out), 32'(model_pc));
      chk("fetch_halted", 32'(halted), 32'h0);
      chk("fetch_strobes", {29'h0, reg_write_en, flags_write_en, port_write_en}, 32'h0);
      flags = f;
      @(negedge clk);
      chk("decode_strobes", {29'h0, reg_write_en, flags_write_en, port_write_en}, 32'h0);
      @(negedge clk);
      e_wr   = (opc == 5'd1) || (opc == 5'd2) || (opc >= 5'd4 && opc <= 5'd7) || (opc == 5'd9);
      e_flg  = (opc >= 5'd4 && opc <= 5'd8);
      e_port = (opc == 5'd10);
      e_sel  = (opc == 5'd1) ? 2'd3 : (opc == 5'd2) ? 2'd1 : (opc == 5'd9) ? 2'd2 : 2'd0;
      e_alu  = (opc == 5'd8) ? 2'd1 : opc[1:0];
      chk("exe_reg_wr", 32'(reg_write_en), 32'(e_wr));
      chk("exe_flag_wr", 32'(flags_write_en), 32'(e_flg));
      chk("exe_port_wr", 32'(port_write_en), 32'(e_port));
      chk("exe_rx", 32'(in_rx_selector), 32'(w[10:8]));
      chk("exe_ry", 32'(in_ry_selector), 32'(w[7:5]));
      chk("exe_imm", 32'(imm), 32'(w[7:0]));
      if (e_wr) chk("exe_reg_in_sel", 32'(reg_in_sel), 32'(e_sel));
      if (e_flg) chk("exe_alu_op", 32'(alu_op), 32'(e_alu));
      taken = (opc == 5'd16) || (opc == 5'd17 && f[0]) ||
              (opc == 5'd18 && !f[0]) || (opc == 5'd19 && f[1]);
      model_pc = taken ? w[7:0] : model_pc + 8'd1;
      hit_halt = (opc == 5'd31);
      @(negedge clk);
   endtask

   initial begin
      bit h;
      reset = 1'b1;
      flags = 2'b00;
      for (int i = 0; i < 256; i++) rom[i] = rand_word();
      rom[0]     = 16'h125A;   // LDI r2, 0x5A
      rom[1]     = 16'h2160;   // ADD r1, r3
      rom[2]     = 16'h4140;   // CMP r1, r2
      rom[3]     = 16'h8810;   // JZ 0x10
      rom[8'h10] = 16'h80FF;   // JMP 0xFF
      rom[8'hFF] = 16'h0000;   // NOP, wraps to 0
      @(negedge clk);
      reset_dut();

      // Directed path: taken JZ, jump to 0xFF, wrap to 0
      run_instr(2'b00, h);
      run_instr(2'b10, h);
      run_instr(2'b00, h);
      run_instr(2'b01, h);
      chk("jz_taken_pc", 32'(pc_out), 32'h10);
      run_instr(2'b00, h);
      chk("jmp_ff_pc", 32'(pc_out), 32'hFF);
      run_instr(2'b00, h);
      chk("wrap_pc", 32'(pc_out), 32'h00);

      // Random program
      for (int i = 0; i < 150; i++) begin
         run_instr(2'($urandom_range(0, 3)), h);
      end

      // Not-taken JZ, then HALT
      rom[4] = 16'hF800;
      reset_dut();
      run_instr(2'b00, h);
      run_instr(2'b00, h);
      run_instr(2'b00, h);
      run_instr(2'b00, h);
      chk("jz_not_taken_pc", 32'(pc_out), 32'h04);
      run_instr(2'b11, h);
      chk("halt_seen", 32'(h), 32'h1);
      for (int i = 0; i < 20; i++) begin
         chk("halt_halted", 32'(halted), 32'h1);
         chk("halt_strobes", {29'h0, reg_write_en, flags_write_en, port_write_en}, 32'h0);
         chk("halt_pc", 32'(pc_out), 32'(model_pc));
         flags = 2'($urandom_range(0, 3));
         @(negedge clk);
      end
      reset_dut();
      chk("post_halt_pc", 32'(pc_out), 32'h0);
      chk("post_halt_halted", 32'(halted), 32'h0);

      // Reset arriving during EXECUTE of OUT
      rom[0] = 16'h5060;
      reset_dut();
      chk("out_fetch_pc", 32'(pc_out), 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("out_port_wr", 32'(port_write_en), 32'h1);
      reset = 1'b1;
      #1;
      chk("out_port_wr_rst", 32'(port_write_en), 32'h0);
      @(posedge clk);
      #1;
      chk("out_rst_pc", 32'(pc_out), 32'h0);
      chk("out_rst_halted", 32'(halted), 32'h0);
      chk("out_rst_port_wr", 32'(port_write_en), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("out_after_pc", 32'(pc_out), 32'h0);
      chk("out_after_port_wr", 32'(port_write_en), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
